// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_arb_pkg
//  Purpose  : Shared types and default constants for the FIFO write-port
//             round-robin arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

   // Arbiter FSM encoding
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   // Default parameter values
   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_WIDTH     = 8;
   localparam int DEF_MAX_BURST = 4;

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin picker. Returns the first set request
//             bit strictly after 'last', wrapping around to bit 0.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
)
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   logic [NUM_REQ-1:0] mask;
   logic [NUM_REQ-1:0] req_hi;

   // Mask keeps only requesters above the last owner; those win first.
   always_comb begin
      mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         mask[i] = (i > int'(last));
      end
      req_hi = req & mask;
   end

   // Lowest set bit of the masked vector, else lowest set bit overall (wrap).
   always_comb begin
      valid = |req;
      idx   = '0;
      if (|req_hi) begin
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_hi[i]) idx = IDX_W'(i);
         end
      end else begin
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
         end
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Round-robin burst arbiter sharing one FIFO write port between
//             NUM_REQ requesters. Honours the FIFO full flag, so it never
//             writes into a full FIFO. One fixed idle cycle between grants.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int IDX_W     = $clog2(NUM_REQ)
)
(
   input  logic                     clk,
   input  logic                     res,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       gnt,
   input  logic                     full,
   output logic                     wr_en,
   output logic [WIDTH-1:0]         wdata,
   output logic [IDX_W-1:0]         owner,
   output logic                     busy
);

   localparam int                CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

   logic                 pick_valid;
   logic [IDX_W-1:0]     pick_idx;
   logic [WIDTH-1:0]     slice [NUM_REQ];
   logic                 owner_req;
   logic [WIDTH-1:0]     owner_data;
   logic                 in_burst;
   logic                 accept;

   // Split the flat requester data bus into per-requester words.
   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
         assign slice[i] = req_data[i*WIDTH +: WIDTH];
      end
   endgenerate

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (req),
      .last  (last_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // Select the current owner's request and data word.
   always_comb begin
      owner_req  = 1'b0;
      owner_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == IDX_W'(i)) begin
            owner_req  = req[i];
            owner_data = slice[i];
         end
      end
   end

   // A beat is consumed only while bursting, requested and the FIFO has room.
   assign in_burst = (state_q == ST_BURST);
   assign accept   = in_burst & owner_req & ~full;
   assign wr_en    = accept;
   assign wdata    = accept ? owner_data : '0;
   assign gnt      = gnt_q;
   assign owner    = owner_q;
   assign busy     = in_burst;

   // Next-state: arbitrate in IDLE, count beats and decide release in BURST.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      owner_d    = owner_q;
      last_d     = last_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d    = ST_BURST;
               gnt_d      = ONE_HOT0 << pick_idx;
               owner_d    = pick_idx;
               beat_cnt_d = '0;
            end
         end
         ST_BURST: begin
            // Release on last beat or when the owner withdraws (even if stalled).
            if (!owner_req || (accept && (beat_cnt_q == LAST_BEAT))) begin
               state_d    = ST_IDLE;
               gnt_d      = '0;
               last_d     = owner_q;
               beat_cnt_d = '0;
            end else if (accept) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // State registers with asynchronous reset; last starts at NUM_REQ-1 so
   // requester 0 has first priority.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         owner_q    <= '0;
         last_q     <= LAST_INIT;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Self-checking bench for fifo_wr_arbiter (4 requesters, 8-bit,
//             bursts of 4) with a behavioural FIFO fill model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        res;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic        full;
   logic [3:0]  gnt;
   logic        wr_en;
   logic [7:0]  wdata;
   logic [1:0]  owner;
   logic        busy;

   // Manual drive and model drive, muxed by mdl_mode
   logic        mdl_mode;
   logic [3:0]  req_man, req_mdl;
   logic [31:0] data_man, data_mdl;
   logic        full_man, full_mdl;

   int          n_checks;
   int          n_fail;

   // Behavioural 16-deep FIFO and requester models
   int          fifo_cnt;
   logic        ovf;
   logic [7:0]  mem [16];
   int          sent [4];

   assign req      = mdl_mode ? req_mdl  : req_man;
   assign req_data = mdl_mode ? data_mdl : data_man;
   assign full     = mdl_mode ? full_mdl : full_man;
   assign full_mdl = (fifo_cnt >= 16);

   fifo_wr_arbiter #(
      .NUM_REQ   (4),
      .WIDTH     (8),
      .MAX_BURST (4)
   ) dut (
      .clk      (clk),
      .res      (res),
      .req      (req),
      .req_data (req_data),
      .gnt      (gnt),
      .full     (full),
      .wr_en    (wr_en),
      .wdata    (wdata),
      .owner    (owner),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each requester i sends 8 words i*16+beat, advancing when a beat is consumed.
   always_comb begin
      req_mdl  = '0;
      data_mdl = '0;
      for (int i = 0; i < 4; i++) begin
         req_mdl[i]        = (sent[i] < 8);
         data_mdl[i*8 +: 8] = 8'(i*16 + sent[i]);
      end
   end

   always @(posedge clk) begin
      if (res) begin
         fifo_cnt <= 0;
         ovf      <= 1'b0;
         for (int i = 0; i < 4; i++) sent[i] <= 0;
      end else if (mdl_mode) begin
         if (wr_en) begin
            if (full_mdl) ovf <= 1'b1;
            else if (fifo_cnt < 16) begin
               mem[fifo_cnt] <= wdata;
               fifo_cnt      <= fifo_cnt + 1;
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (gnt[i] && req[i] && !full) sent[i] <= sent[i] + 1;
         end
      end
   end

   typedef struct {
      logic        rst_before;
      logic [3:0]  req;
      logic [31:0] data;
      logic        full;
      logic [3:0]  gnt;
      logic        wr;
      logic [7:0]  wdata;
      logic        busy;
      logic [1:0]  owner;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rb, input logic [3:0] r, input logic [31:0] d,
                      input logic f, input logic [3:0] g, input logic w,
                      input logic [7:0] wd, input logic b, input logic [1:0] o);
      vec_t v;
      v.rst_before = rb; v.req = r; v.data = d; v.full = f;
      v.gnt = g; v.wr = w; v.wdata = wd; v.busy = b; v.owner = o;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      res = 1'b1; req_man = '0; data_man = '0; full_man = 1'b0;
      repeat (2) @(posedge clk);
      #1 res = 1'b0;
   endtask

   // Drive inputs just after the edge, return at the following falling edge.
   task automatic step(input logic [3:0] r, input logic [31:0] d, input logic f);
      @(posedge clk); #1;
      req_man = r; data_man = d; full_man = f;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d4;
      int          writes;
      n_checks = 0; n_fail = 0;
      mdl_mode = 1'b0;
      res = 1'b1; req_man = 4'b1111; data_man = 32'hFFFF_FFFF; full_man = 1'b0;

      // Reset state, even with every request high
      @(negedge clk);
      chk("rst_gnt",   32'(gnt),   0);
      chk("rst_wr",    32'(wr_en), 0);
      chk("rst_wdata", 32'(wdata), 0);
      chk("rst_busy",  32'(busy),  0);
      chk("rst_owner", 32'(owner), 0);

      // Single requester 2: AA, BB, CC, non-owner bits ignored mid-burst
      add(1, 4'b0000, 32'h0,        0, 4'b0000, 0, 8'h00, 0, 0);
      add(0, 4'b0100, 32'h00AA0000, 0, 4'b0000, 0, 8'h00, 0, 0);
      add(0, 4'b0100, 32'h00AA0000, 0, 4'b0100, 1, 8'hAA, 1, 2);
      add(0, 4'b0111, 32'h00BB0000, 0, 4'b0100, 1, 8'hBB, 1, 2);
      add(0, 4'b0100, 32'h00CC0000, 0, 4'b0100, 1, 8'hCC, 1, 2);
      add(0, 4'b0000, 32'h0,        0, 4'b0100, 0, 8'h00, 1, 2);
      add(0, 4'b0000, 32'h0,        0, 4'b0000, 0, 8'h00, 0, 0);

      // All four requesting: owners 0,1,2,3,0; 4 beats each; one bubble
      d4 = 32'hA3A2A1A0;
      add(1, 4'b1111, d4, 0, 4'b0000, 0, 8'h00, 0, 0);
      for (int g = 0; g < 5; g++) begin
         for (int b = 0; b < ((g == 4) ? 1 : 4); b++) begin
            add(0, 4'b1111, d4, 0, 4'(1 << (g % 4)), 1, 8'(8'hA0 + (g % 4)), 1, 2'(g % 4));
         end
         if (g < 4) add(0, 4'b1111, d4, 0, 4'b0000, 0, 8'h00, 0, 0);
      end

      foreach (vecs[i]) begin
         if (vecs[i].rst_before) do_reset();
         step(vecs[i].req, vecs[i].data, vecs[i].full);
         chk($sformatf("v%0d_gnt", i),   32'(gnt),   32'(vecs[i].gnt));
         chk($sformatf("v%0d_wr", i),    32'(wr_en), 32'(vecs[i].wr));
         chk($sformatf("v%0d_wdata", i), 32'(wdata), 32'(vecs[i].wdata));
         chk($sformatf("v%0d_busy", i),  32'(busy),  32'(vecs[i].busy));
         if (vecs[i].busy) chk($sformatf("v%0d_owner", i), 32'(owner), 32'(vecs[i].owner));
      end

      // Owner 1 stalled by full at beat 2, then finishes 2 more beats
      do_reset();
      step(4'b0010, 32'h00001100, 0);
      chk("st_idle_busy", 32'(busy), 0);
      step(4'b0010, 32'h00001100, 0);
      chk("st_b0_wr", 32'(wr_en), 1);
      step(4'b0010, 32'h00001200, 0);
      chk("st_b1_wdata", 32'(wdata), 32'h12);
      for (int k = 0; k < 5; k++) begin
         step(4'b0010, 32'h00001300, 1);
         chk($sformatf("st_full%0d_wr", k),   32'(wr_en), 0);
         chk($sformatf("st_full%0d_gnt", k),  32'(gnt),   32'h2);
         chk($sformatf("st_full%0d_beat", k), 32'(dut.beat_cnt_q), 2);
      end
      writes = 0;
      step(4'b0010, 32'h00001300, 0);
      chk("st_b2_wdata", 32'(wdata), 32'h13);
      writes += int'(wr_en);
      step(4'b0010, 32'h00001400, 0);
      chk("st_b3_wdata", 32'(wdata), 32'h14);
      writes += int'(wr_en);
      step(4'b0010, 32'h00001500, 0);
      writes += int'(wr_en);
      chk("st_writes", 32'(writes), 2);
      chk("st_rel_busy", 32'(busy), 0);
      chk("st_rel_gnt",  32'(gnt),  0);

      // Owner 0 drops after one beat; pending requester 3 follows after a bubble
      do_reset();
      step(4'b1001, 32'h30000001, 0);
      step(4'b1001, 32'h30000001, 0);
      chk("dr_b0_gnt",   32'(gnt),   32'h1);
      chk("dr_b0_wdata", 32'(wdata), 32'h01);
      step(4'b1000, 32'h30000001, 0);
      chk("dr_drop_gnt", 32'(gnt),   32'h1);
      chk("dr_drop_wr",  32'(wr_en), 0);
      step(4'b1000, 32'h30000001, 0);
      chk("dr_bub_gnt",  32'(gnt),  0);
      chk("dr_bub_busy", 32'(busy), 0);
      step(4'b1000, 32'h30000001, 0);
      chk("dr_g3_gnt",   32'(gnt),   32'h8);
      chk("dr_g3_owner", 32'(owner), 3);
      chk("dr_g3_wdata", 32'(wdata), 32'h30);

      // Asynchronous reset in the middle of owner 2's burst
      do_reset();
      step(4'b0100, 32'h00550000, 0);
      step(4'b0100, 32'h00550000, 0);
      step(4'b0100, 32'h00550000, 0);
      chk("ar_pre_wr", 32'(wr_en), 1);
      #2 res = 1'b1;
      #1;
      chk("ar_gnt",  32'(gnt),   0);
      chk("ar_wr",   32'(wr_en), 0);
      chk("ar_busy", 32'(busy),  0);
      @(posedge clk); #1;
      req_man = 4'b1001; data_man = 32'h77000066;
      @(posedge clk); #1 res = 1'b0;
      @(negedge clk);
      chk("ar_idle_gnt", 32'(gnt), 0);
      step(4'b1001, 32'h77000066, 0);
      chk("ar_first_gnt",   32'(gnt),   32'h1);
      chk("ar_first_wdata", 32'(wdata), 32'h66);

      // Fill a 16-deep FIFO from 4 requesters of 8 words each
      mdl_mode = 1'b1;
      do_reset();
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("ff_count", 32'(fifo_cnt), 16);
      chk("ff_full",  32'(full),     1);
      chk("ff_ovf",   32'(ovf),      0);
      chk("ff_gnt",   32'(gnt),      32'h1);
      chk("ff_busy",  32'(busy),     1);
      chk("ff_wr",    32'(wr_en),    0);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("ff_mem%0d", k), 32'(mem[k]), 32'(16*(k/4) + (k%4)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the team's asyn_fifo between NUM_REQ requesters in the write-clock domain. It grants one requester at a time for bursts of up to MAX_BURST beats and forwards that requester's data onto the FIFO's wr_en/wdata. It honours the FIFO full flag, so it never causes a FIFO overflow. It instantiates next to the FIFO and runs on the FIFO's write clock.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 8, data width; must match the FIFO WIDTH
MAX_BURST, 4, maximum accepted beats per grant (>=1)
IDX_W, $clog2(NUM_REQ), owner index width (derived; do not override)

Ports:
clk  in  1  write clock; the same net as the FIFO wr_clk
res  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester write request; held high while the requester has data
req_data  in  NUM_REQ*WIDTH  requester i data on bits [i*WIDTH +: WIDTH]
gnt  out  NUM_REQ  one-hot registered grant; all zero when no owner
full  in  1  FIFO full flag
wr_en  out  1  FIFO write enable
wdata  out  WIDTH  FIFO write data
owner  out  IDX_W  index of the current or last owner
busy  out  1  high while in BURST

Behaviour:
- States: IDLE and BURST. All registers are reset asynchronously by res.
- Reset values: state=IDLE, gnt=0, owner=0, last=NUM_REQ-1 so requester 0 has first priority, beat_cnt=0, busy=0, wr_en=0, wdata=0.
- Accept condition: accept = busy & req[owner] & ~full. wr_en = accept, combinational from the registered gnt/owner, req and full.
- Write data: wdata = req_data slice owner when accept is high, otherwise 0.
- IDLE: if |req is high at the clock edge, select the first set bit searching from (last+1) mod NUM_REQ with wrap-around. On the next cycle gnt is one-hot on that index, owner = index, beat_cnt = 0, state = BURST.
- Latency: req rising while in IDLE gives gnt one cycle later; the first write happens in that same cycle if full=0.
- BURST, on each accept: beat_cnt increments. beat_cnt is IDX-independent and counts 0..MAX_BURST-1.
- BURST release, at the edge: when (accept & beat_cnt==MAX_BURST-1) or req[owner]==0. On release: gnt=0, busy=0, last=owner, beat_cnt=0, state=IDLE.
- Re-arbitration bubble: always one idle cycle between grants; this is an intentional fixed bubble.
- full=1 during BURST: grant is held, beat_cnt is frozen, wr_en=0. There is no timeout. A requester that drops req while stalled is released normally.
- Requester contract: a granted requester treats gnt[i] & req[i] & ~full as "beat consumed" and advances its data on the next cycle.
- Non-owner req bits are ignored during BURST.
- Overflow: wr_en is never high while full=1, so the FIFO overflow flag never asserts due to this block.
- MAX_BURST=1: every accepted beat releases the grant. Under contention the grant cycles through the requesters, with one bubble per beat.
- Reset mid-burst: gnt, busy and wr_en drop asynchronously. After reset deassertion, arbitration restarts with requester 0 highest priority.
- owner holds its last value in IDLE. The bench checks owner only when busy=1.

Decomposition:
- Package fifo_arb_pkg:
  - state encoding (IDLE=1'b0, BURST=1'b1)
  - default parameter constants
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req, last.
  - Outputs: valid, idx.
  - Implement with a double-width mask or a rotate-and-priority-encode.
- The FSM, beat counter and output muxing live in fifo_wr_arbiter.

Test Plan:
1. Only req[2] high with data AA,BB,CC, then drop; full=0 -> gnt=4'b0100 one cycle after req, wr_en high 3 cycles with wdata AA,BB,CC, then gnt=0 and busy=0.
2. req=4'b1111 held continuously, MAX_BURST=4 -> owners 0,1,2,3,0 in order; exactly 4 writes per grant; one idle cycle between grants.
3. Owner 1 at beat 2 of 4 while full is held high for 5 cycles -> wr_en=0, gnt stays 4'b0010, beat_cnt frozen at 2; after full drops, exactly 2 more beats, then release.
4. Owner 0 drops req after 1 beat while req[3] is pending -> release, one idle cycle, then gnt=4'b1000.
5. res asserted mid-burst of owner 2 -> gnt, wr_en and busy go to 0 immediately; after reset with req[0] and req[3] both high, the grant goes to 0.
6. Integration with asyn_fifo (FIFO_SIZE=16) and no reads; 4 requesters x 8 beats each -> exactly 16 words written; full=1; overflow never asserts; remaining requesters stall with gnt held.
